// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for mem_arbiter_rr2
package arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr2_if.sv
// rtl/mem_arbiter_rr2_if.sv - requester and memory bundle for mem_arbiter_rr2; Lock0/Lock1 exist under ARB_LOCK_EN
interface mem_arbiter_rr2_if
  import arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              Req0, Req1;
  logic [ADDR_W-1:0] Addr0, Addr1;
  logic [DATA_W-1:0] Wdata0, Wdata1;
  logic              W0, W1;
`ifdef ARB_LOCK_EN
  logic              Lock0, Lock1;
`endif
  logic              Gnt0, Gnt1;
  logic              Ack0, Ack1;
  logic [DATA_W-1:0] Rdata0, Rdata1;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemDout;
  logic              MemW;
  logic [DATA_W-1:0] MemDin;

  modport slave (
`ifdef ARB_LOCK_EN
    input  Lock0, Lock1,
`endif
    input  Req0, Req1, Addr0, Addr1, Wdata0, Wdata1, W0, W1, MemDin,
    output Gnt0, Gnt1, Ack0, Ack1, Rdata0, Rdata1, MemAddress, MemDout, MemW
  );

  modport master (
`ifdef ARB_LOCK_EN
    output Lock0, Lock1,
`endif
    output Req0, Req1, Addr0, Addr1, Wdata0, Wdata1, W0, W1, MemDin,
    input  Gnt0, Gnt1, Ack0, Ack1, Rdata0, Rdata1, MemAddress, MemDout, MemW
  );

endinterface

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational 2-way round-robin selector; lock owner filter under ARB_LOCK_EN
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic Req0,
  input  logic Req1,
  input  logic Last,
`ifdef ARB_LOCK_EN
  input  logic LockValid,
  input  logic LockOwner,
`endif
  output logic Valid,
  output logic Sel
);

  always_comb begin
    Valid = Req0 | Req1;
    Sel   = REQ0;
    if (Req0 && Req1) begin
      Sel = ~Last;
    end else if (Req1) begin
      Sel = REQ1;
    end
`ifdef ARB_LOCK_EN
    // a locked owner hides the other requester entirely
    if (LockValid) begin
      Sel   = LockOwner;
      Valid = (LockOwner == REQ1) ? Req1 : Req0;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter_rr2.sv
// rtl/mem_arbiter_rr2.sv - two-requester round-robin arbiter for a single-port memory; ARB_LOCK_EN adds locked access
module mem_arbiter_rr2
  import arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic              Clock,
  input logic              Resetn,
  mem_arbiter_rr2_if.slave bus
);

  state_t state, state_nxt;

  logic              last, owner;
  logic              pick_valid, pick_sel;
  logic              gnt0_q, gnt1_q, ack0_q, ack1_q, mem_w_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_dout_q, rdata0_q, rdata1_q;
`ifdef ARB_LOCK_EN
  logic              lock_valid, lock_owner;
`endif

  arb_rr_pick u_pick (
    .Req0      (bus.Req0),
    .Req1      (bus.Req1),
    .Last      (last),
`ifdef ARB_LOCK_EN
    .LockValid (lock_valid),
    .LockOwner (lock_owner),
`endif
    .Valid     (pick_valid),
    .Sel       (pick_sel)
  );

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = pick_valid ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last       <= REQ1;
      owner      <= REQ0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      mem_w_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef ARB_LOCK_EN
      lock_valid <= 1'b0;
      lock_owner <= REQ0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner      <= pick_sel;
            gnt0_q     <= (pick_sel == REQ0);
            gnt1_q     <= (pick_sel == REQ1);
            mem_addr_q <= (pick_sel == REQ1) ? bus.Addr1  : bus.Addr0;
            mem_dout_q <= (pick_sel == REQ1) ? bus.Wdata1 : bus.Wdata0;
            mem_w_q    <= (pick_sel == REQ1) ? bus.W1     : bus.W0;
`ifdef ARB_LOCK_EN
            lock_valid <= (pick_sel == REQ1) ? bus.Lock1  : bus.Lock0;
            lock_owner <= pick_sel;
`endif
          end
        end
        ACCESS: begin
          // mem_w_q still holds the granted W here, so it doubles as the read flag
          mem_w_q <= 1'b0;
          if (!mem_w_q) begin
            if (owner == REQ1) rdata1_q <= bus.MemDin;
            else               rdata0_q <= bus.MemDin;
          end
          ack0_q <= (owner == REQ0);
          ack1_q <= (owner == REQ1);
          last   <= owner;
        end
        default: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Gnt0       = gnt0_q;
  assign bus.Gnt1       = gnt1_q;
  assign bus.Ack0       = ack0_q;
  assign bus.Ack1       = ack1_q;
  assign bus.Rdata0     = rdata0_q;
  assign bus.Rdata1     = rdata1_q;
  assign bus.MemAddress = mem_addr_q;
  assign bus.MemDout    = mem_dout_q;
  assign bus.MemW       = mem_w_q;

endmodule

// File: tb/tb_mem_arbiter_rr2.sv
// tb/tb_mem_arbiter_rr2.sv - randomized and directed bench for mem_arbiter_rr2 against a transaction-level model
module tb_mem_arbiter_rr2;

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  mem_arbiter_rr2_if bus ();

  mem_arbiter_rr2 dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 37) ^ 16'h5A5A;
  endfunction

  // memory sits behind the arbiter's registered address
  logic [15:0] ram [256];
  bit          written [256];
  assign bus.MemDin = written[bus.MemAddress[7:0]] ? ram[bus.MemAddress[7:0]] : init_val(int'(bus.MemAddress[7:0]));
  always @(posedge Clock) begin
    if (bus.MemW) begin
      ram[bus.MemAddress[7:0]]     <= bus.MemDout;
      written[bus.MemAddress[7:0]] <= 1'b1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // transaction-level reference: one access occupies the grant edge plus two more edges
  logic [15:0] mmem [256];
  logic [15:0] rexp [2];
  int          edge_n = 0;
  int          g_edge = 0;
  bit          busy, g_who, g_w, last_m, lock_act, lock_own;
  logic [15:0] g_addr, g_data;
  bit          obs [$];
  bit          pg0, pg1;
  int          memw_cnt;
  logic [15:0] ack_rdata;

  task automatic model_reset();
    busy     = 1'b0;
    last_m   = 1'b1;
    rexp[0]  = '0;
    rexp[1]  = '0;
    lock_act = 1'b0;
  endtask

  task automatic model_edge();
    bit r0, r1, who;
    edge_n++;
    if (busy) begin
      if (edge_n == g_edge + 1) begin
        if (g_w) mmem[g_addr[7:0]] = g_data;
        else     rexp[g_who] = mmem[g_addr[7:0]];
        last_m = g_who;
      end else if (edge_n == g_edge + 2) begin
        busy = 1'b0;
      end
    end else begin
      r0 = bus.Req0;
      r1 = bus.Req1;
      if (lock_act) begin
        if (lock_own) r0 = 1'b0;
        else          r1 = 1'b0;
      end
      if (r0 || r1) begin
        who    = (r0 && r1) ? !last_m : r1;
        busy   = 1'b1;
        g_edge = edge_n;
        g_who  = who;
        g_addr = who ? bus.Addr1  : bus.Addr0;
        g_data = who ? bus.Wdata1 : bus.Wdata0;
        g_w    = who ? bus.W1     : bus.W0;
`ifdef ARB_LOCK_EN
        lock_act = who ? bus.Lock1 : bus.Lock0;
        lock_own = who;
`endif
      end
    end
  endtask

  task automatic check_outputs();
    int ph;
    ph = busy ? edge_n - g_edge : -1;
    check_eq("gnt0",  bus.Gnt0,  32'(busy && !g_who));
    check_eq("gnt1",  bus.Gnt1,  32'(busy && g_who));
    check_eq("ack0",  bus.Ack0,  32'(ph == 1 && !g_who));
    check_eq("ack1",  bus.Ack1,  32'(ph == 1 && g_who));
    check_eq("memw",  bus.MemW,  32'(ph == 0 && g_w));
    check_eq("gnt_excl", 32'(bus.Gnt0 & bus.Gnt1), 0);
    check_eq("rdata0", bus.Rdata0, rexp[0]);
    check_eq("rdata1", bus.Rdata1, rexp[1]);
    if (ph == 0) begin
      check_eq("mem_addr", bus.MemAddress, g_addr);
      check_eq("mem_dout", bus.MemDout, g_data);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    check_outputs();
    if (bus.MemW) memw_cnt++;
    if (busy && edge_n == g_edge + 1) ack_rdata = g_who ? bus.Rdata1 : bus.Rdata0;
    if (bus.Gnt0 && !pg0) obs.push_back(1'b0);
    if (bus.Gnt1 && !pg1) obs.push_back(1'b1);
    pg0 = bus.Gnt0;
    pg1 = bus.Gnt1;
  endtask

  task automatic pulse_reset();
    Resetn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("rst_addr", bus.MemAddress, 0);
    check_eq("rst_dout", bus.MemDout, 0);
    pg0 = 1'b0;
    pg1 = 1'b0;
    #1;
    Resetn = 1'b1;
  endtask

  task automatic drop_owner();
    if (g_who) bus.Req1 = 1'b0;
    else       bus.Req0 = 1'b0;
  endtask

  task automatic run_cycles(input int n, input bit hold);
    for (int k = 0; k < n; k++) begin
      step();
      if (!hold && busy && edge_n == g_edge + 1) drop_owner();
    end
  endtask

  task automatic new_txn(input bit i);
    logic [15:0] a, d;
    bit w, lk;
    a  = 16'($urandom_range(0, 7));
    d  = 16'($urandom);
    w  = ($urandom_range(0, 1) == 1);
    lk = ($urandom_range(0, 3) == 0);
    if (i) begin
      bus.Req1 = 1'b1; bus.Addr1 = a; bus.Wdata1 = d; bus.W1 = w;
    end else begin
      bus.Req0 = 1'b1; bus.Addr0 = a; bus.Wdata0 = d; bus.W0 = w;
    end
`ifdef ARB_LOCK_EN
    if (i) bus.Lock1 = lk;
    else   bus.Lock0 = lk;
`else
    if (lk) d = '0;
`endif
  endtask

  initial begin
    bit found;
    int n0;
    for (int a = 0; a < 256; a++) mmem[a] = init_val(a);
    bus.Req0 = 1'b0; bus.Addr0 = '0; bus.Wdata0 = '0; bus.W0 = 1'b0;
    bus.Req1 = 1'b0; bus.Addr1 = '0; bus.Wdata1 = '0; bus.W1 = 1'b0;
`ifdef ARB_LOCK_EN
    bus.Lock0 = 1'b0; bus.Lock1 = 1'b0;
`endif
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    pulse_reset();

    // single write from requester 0
    memw_cnt = 0;
    bus.Req0 = 1'b1; bus.W0 = 1'b1; bus.Addr0 = 16'h0010; bus.Wdata0 = 16'hABCD;
    run_cycles(5, 1'b0);
    check_eq("wr_memw_pulses", memw_cnt, 1);
    check_eq("wr_grant_who", obs.size() == 1 ? 32'(obs[0]) : 32'hFFFF, 0);

    // read back through requester 1
    memw_cnt = 0;
    ack_rdata = '0;
    bus.Req1 = 1'b1; bus.W1 = 1'b0; bus.Addr1 = 16'h0010;
    run_cycles(5, 1'b0);
    check_eq("rd1_value", ack_rdata, 16'hABCD);
    check_eq("rd1_memw_pulses", memw_cnt, 0);

    // both held: strict alternation
    obs.delete();
    bus.Req0 = 1'b1; bus.W0 = 1'b0; bus.Addr0 = 16'h0003;
    bus.Req1 = 1'b1; bus.W1 = 1'b0; bus.Addr1 = 16'h0005;
    run_cycles(18, 1'b1);
    check_eq("alt_count", obs.size(), 6);
    for (int k = 0; k < obs.size() && k < 6; k++)
      check_eq($sformatf("alt_order_%0d", k), 32'(obs[k]), 32'(k % 2));

    // reset during requester 1's ACCESS cycle
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      if (busy && g_who && edge_n == g_edge) found = 1'b1;
    end
    check_eq("find_access1", 32'(found), 1);
    pulse_reset();
    obs.delete();
    step();
    check_eq("post_rst_first", obs.size() > 0 ? 32'(obs[0]) : 32'hFFFF, 0);
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    run_cycles(4, 1'b0);

`ifdef ARB_LOCK_EN
    pulse_reset();
    obs.delete();
    n0 = 0;
    bus.Req0 = 1'b1; bus.W0 = 1'b0; bus.Lock0 = 1'b1;
    bus.Req1 = 1'b1; bus.W1 = 1'b0; bus.Lock1 = 1'b0;
    for (int k = 0; k < 30 && obs.size() < 4; k++) begin
      step();
      if (busy && edge_n == g_edge + 1 && !g_who) begin
        n0++;
        if (n0 == 2) bus.Lock0 = 1'b0;
      end
    end
    check_eq("lock_count", obs.size() >= 4 ? 4 : obs.size(), 4);
    for (int k = 0; k < obs.size() && k < 4; k++)
      check_eq($sformatf("lock_order_%0d", k), 32'(obs[k]), k == 3 ? 1 : 0);
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    run_cycles(4, 1'b0);
`else
    n0 = 0;
`endif

    // randomized traffic, including early Req drops and back-to-back requests
    for (int c = 0; c < 600; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        bit r;
        r = (i == 1) ? bus.Req1 : bus.Req0;
        if (r) begin
          if (busy && edge_n == g_edge + 1 && g_who == 1'(i)) begin
            if ($urandom_range(0, 1) == 1) new_txn(1'(i));
            else if (i == 1) bus.Req1 = 1'b0;
            else bus.Req0 = 1'b0;
          end else if (busy && edge_n == g_edge && g_who == 1'(i) && $urandom_range(0, 9) == 0) begin
            if (i == 1) bus.Req1 = 1'b0;
            else bus.Req0 = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_txn(1'(i));
        end
      end
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
`ifdef ARB_LOCK_EN
    bus.Lock0 = 1'b0; bus.Lock1 = 1'b0;
`endif
    run_cycles(6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
